// File: rtl/ad80305_pkg.sv
// Shared definitions for the AD80305 receive interface: state encoding,
// beat/sample widths and the per-beat frame pattern.
package ad80305_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

    localparam int HALF_W   = 6;
    localparam int SAMPLE_W = 12;

    // Frame bit expected on beats b0..b3, b0 in the MSB.
    localparam logic [3:0] FRAME_PATTERN = 4'b1100;

    // Frame bit expected for a given beat index.
    function automatic logic expected_frame(input logic [1:0] idx);
        return FRAME_PATTERN[2'd3 - idx];
    endfunction

endpackage

// File: rtl/ad80305_rx_if_ddr_dcs_if.sv
// Beat input bus and reassembled sample outputs of the receive interface.
interface ad80305_rx_if_ddr_dcs_if;
    import ad80305_pkg::*;

    logic                i_rx_valid;
    logic                i_rx_frame;
    logic [HALF_W-1:0]   i_rx_data;
    logic                o_iqdata_fp;
    logic [SAMPLE_W-1:0] o_idata;
    logic [SAMPLE_W-1:0] o_qdata;
    logic                o_lock;
    logic                o_frame_err;

    modport master (
        output i_rx_valid, i_rx_frame, i_rx_data,
        input  o_iqdata_fp, o_idata, o_qdata, o_lock, o_frame_err
    );

    modport slave (
        input  i_rx_valid, i_rx_frame, i_rx_data,
        output o_iqdata_fp, o_idata, o_qdata, o_lock, o_frame_err
    );
endinterface

// File: rtl/ad80305_lvds_beat_align.sv
// Beat alignment: detects the 0->1 frame edge that marks b0, tracks the beat
// index across valid beats and flags beats whose frame bit breaks the pattern.
module ad80305_lvds_beat_align
    import ad80305_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic       frame,
    output logic [1:0] beat_idx,
    output logic       beat_edge,
    output logic       beat_err
);

    // idx_r holds the index the next valid beat will take.
    logic [1:0] idx_r;
    logic       prev_frame_r;

    // Classify the current beat: index, b0 edge and pattern mismatch.
    always_comb begin
        beat_edge = 1'b0;
        beat_idx  = idx_r;
        beat_err  = 1'b0;
        if (valid) begin
            beat_edge = frame & ~prev_frame_r;
            if (beat_edge) begin
                beat_idx = 2'd0;
            end else begin
                beat_idx = idx_r;
            end
            beat_err = (frame != expected_frame(beat_idx));
        end else begin
            beat_edge = 1'b0;
            beat_err  = 1'b0;
        end
    end

    // Advance the index and remember the frame bit on every valid beat only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r        <= 2'd0;
            prev_frame_r <= 1'b0;
        end else if (valid) begin
            idx_r        <= beat_idx + 2'd1;
            prev_frame_r <= frame;
        end
    end

endmodule

// File: rtl/ad80305_rx_if_ddr_dcs.sv
// AD80305 receive interface: reassembles 12-bit I/Q samples from four 6-bit
// DDR beats, hunts for frame alignment and only emits samples while locked.
module ad80305_rx_if_ddr_dcs
    import ad80305_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 16
)(
    input  logic                      i_fpga_clk,
    input  logic                      i_fpga_rst,
    ad80305_rx_if_ddr_dcs_if.slave    rx
);

    localparam int LC_W  = $clog2(LOCK_CNT + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [1:0]          beat_idx_s;
    logic                beat_edge_s;
    logic                beat_err_s;

    rx_state_t           state_r;
    logic [LC_W-1:0]     good_cnt_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [HALF_W-1:0]   i_hi_r;
    logic [HALF_W-1:0]   q_hi_r;
    logic [HALF_W-1:0]   i_lo_r;
    logic                strobe_r;
    logic [SAMPLE_W-1:0] idata_r;
    logic [SAMPLE_W-1:0] qdata_r;
    logic                lock_r;
    logic                frame_err_r;

    ad80305_lvds_beat_align u_align (
        .clk       (i_fpga_clk),
        .rst_n     (i_fpga_rst),
        .valid     (rx.i_rx_valid),
        .frame     (rx.i_rx_frame),
        .beat_idx  (beat_idx_s),
        .beat_edge (beat_edge_s),
        .beat_err  (beat_err_s)
    );

    // Capture the first three half-words; b3 is used straight off the bus.
    always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
        if (!i_fpga_rst) begin
            i_hi_r <= '0;
            q_hi_r <= '0;
            i_lo_r <= '0;
        end else if (rx.i_rx_valid) begin
            case (beat_idx_s)
                2'd0:    i_hi_r <= rx.i_rx_data;
                2'd1:    q_hi_r <= rx.i_rx_data;
                2'd2:    i_lo_r <= rx.i_rx_data;
                default: ;
            endcase
        end
    end

    // Idle-cycle counter; saturates and restarts on every valid beat.
    always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
        if (!i_fpga_rst) begin
            tmo_cnt_r <= '0;
        end else if (rx.i_rx_valid) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r != TMO_W'(TIMEOUT)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Lock FSM with registered lock/error/strobe and sample outputs.
    // In SYNC and LOCKED any bad beat leaves immediately, so a b3 reached in
    // those states always completes a clean sample started on a b0.
    always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
        if (!i_fpga_rst) begin
            state_r     <= ST_HUNT;
            good_cnt_r  <= '0;
            strobe_r    <= 1'b0;
            idata_r     <= '0;
            qdata_r     <= '0;
            lock_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            strobe_r    <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    if (beat_edge_s) begin
                        state_r    <= ST_SYNC;
                        good_cnt_r <= '0;
                    end
                end
                ST_SYNC: begin
                    if (beat_err_s) begin
                        state_r <= ST_HUNT;
                    end else if (rx.i_rx_valid && (beat_idx_s == 2'd3)) begin
                        if (good_cnt_r == LC_W'(LOCK_CNT - 1)) begin
                            state_r  <= ST_LOCKED;
                            lock_r   <= 1'b1;
                            strobe_r <= 1'b1;
                            idata_r  <= {i_hi_r, i_lo_r};
                            qdata_r  <= {q_hi_r, rx.i_rx_data};
                        end
                        good_cnt_r <= good_cnt_r + LC_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (beat_err_s) begin
                        state_r     <= ST_HUNT;
                        lock_r      <= 1'b0;
                        frame_err_r <= 1'b1;
                    end else if (rx.i_rx_valid && (beat_idx_s == 2'd3)) begin
                        strobe_r <= 1'b1;
                        idata_r  <= {i_hi_r, i_lo_r};
                        qdata_r  <= {q_hi_r, rx.i_rx_data};
                    end else if (!rx.i_rx_valid &&
                                 (tmo_cnt_r == TMO_W'(TIMEOUT - 1))) begin
                        state_r     <= ST_HUNT;
                        lock_r      <= 1'b0;
                        frame_err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                    lock_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.o_iqdata_fp = strobe_r;
    assign rx.o_idata     = idata_r;
    assign rx.o_qdata     = qdata_r;
    assign rx.o_lock      = lock_r;
    assign rx.o_frame_err = frame_err_r;

endmodule

// File: tb/tb_ad80305_rx_if_ddr_dcs.sv
// Directed bench for ad80305_rx_if_ddr_dcs: lock acquisition, gapped stream,
// frame error, timeout, async reset mid-sample and mid-sample stream start.
module tb_ad80305_rx_if_ddr_dcs;

    logic clk = 1'b0;
    logic rst_n;

    always #4 clk = ~clk;

    ad80305_rx_if_ddr_dcs_if rx_bus ();

    ad80305_rx_if_ddr_dcs #(.LOCK_CNT(4), .TIMEOUT(16)) dut (
        .i_fpga_clk (clk),
        .i_fpga_rst (rst_n),
        .rx         (rx_bus)
    );

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int err_pulses = 0;
    logic [11:0] sq_i[$];
    logic [11:0] sq_q[$];
    int          sq_t[$];

    // Record every strobe and error pulse, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rx_bus.o_iqdata_fp === 1'b1) begin
            sq_i.push_back(rx_bus.o_idata);
            sq_q.push_back(rx_bus.o_qdata);
            sq_t.push_back(cyc);
        end
        if (rx_bus.o_frame_err === 1'b1) err_pulses++;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one valid beat; returns just after the following falling edge.
    task automatic beat(input logic f, input logic [5:0] d);
        rx_bus.i_rx_valid = 1'b1;
        rx_bus.i_rx_frame = f;
        rx_bus.i_rx_data  = d;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_bus.i_rx_valid = 1'b0;
        rx_bus.i_rx_frame = 1'b0;
        rx_bus.i_rx_data  = 6'd0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One full sample b0..b3, optionally with one idle cycle between beats.
    task automatic sample(input logic [11:0] i, input logic [11:0] q, input bit gap);
        beat(1'b1, i[11:6]);
        if (gap) idle(1);
        beat(1'b1, q[11:6]);
        if (gap) idle(1);
        beat(1'b0, i[5:0]);
        if (gap) idle(1);
        beat(1'b0, q[5:0]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int e0;
        logic [11:0] vi;
        logic [11:0] vq;

        rx_bus.i_rx_valid = 1'b0;
        rx_bus.i_rx_frame = 1'b0;
        rx_bus.i_rx_data  = 6'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk1 ("rst_fp",    rx_bus.o_iqdata_fp, 1'b0);
        chk12("rst_idata", rx_bus.o_idata,     12'h000);
        chk12("rst_qdata", rx_bus.o_qdata,     12'h000);
        chk1 ("rst_lock",  rx_bus.o_lock,      1'b0);
        chk1 ("rst_err",   rx_bus.o_frame_err, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Continuous stream: lock after the 4th frame, 4th frame emitted.
        for (int k = 0; k < 3; k++) begin
            sample(12'h5A3, 12'hC3F, 1'b0);
            chk1("pre_lock_lock", rx_bus.o_lock,      1'b0);
            chk1("pre_lock_fp",   rx_bus.o_iqdata_fp, 1'b0);
        end
        beat(1'b1, 6'h16);
        beat(1'b1, 6'h30);
        beat(1'b0, 6'h23);
        chk1("lock_before_b3", rx_bus.o_lock, 1'b0);
        beat(1'b0, 6'h3F);
        chk1 ("lock_rise",    rx_bus.o_lock,      1'b1);
        chk1 ("first_fp",     rx_bus.o_iqdata_fp, 1'b1);
        chk12("first_idata",  rx_bus.o_idata,     12'h5A3);
        chk12("first_qdata",  rx_bus.o_qdata,     12'hC3F);
        beat(1'b1, 6'h16);
        chk1("fp_one_cycle", rx_bus.o_iqdata_fp, 1'b0);
        beat(1'b1, 6'h30);
        beat(1'b0, 6'h23);
        beat(1'b0, 6'h3F);
        chk1 ("fifth_fp",    rx_bus.o_iqdata_fp, 1'b1);
        chk12("fifth_idata", rx_bus.o_idata,     12'h5A3);
        chk12("fifth_qdata", rx_bus.o_qdata,     12'hC3F);
        idle(1);

        // Valid every other cycle: one strobe per 8 cycles, counting values.
        n0 = sq_i.size();
        for (int n = 1; n <= 6; n++) begin
            sample(12'(n), 12'h800 + 12'(n), 1'b1);
            idle(1);
        end
        chki("gap_strobe_count", sq_i.size() - n0, 6);
        for (int k = 0; k < 6; k++) begin
            chk12("gap_idata", sq_i[n0 + k], 12'(k + 1));
            chk12("gap_qdata", sq_q[n0 + k], 12'h800 + 12'(k + 1));
            if (k > 0) chki("gap_spacing", sq_t[n0 + k] - sq_t[n0 + k - 1], 8);
        end
        chk1("gap_lock", rx_bus.o_lock, 1'b1);

        // Frame bit forced high on b2 while locked.
        e0 = err_pulses;
        vi = 12'h123;
        vq = 12'h456;
        beat(1'b1, vi[11:6]);
        beat(1'b1, vq[11:6]);
        beat(1'b1, vi[5:0]);
        chk1("ferr_pulse", rx_bus.o_frame_err, 1'b1);
        chk1("ferr_lock",  rx_bus.o_lock,      1'b0);
        beat(1'b0, vq[5:0]);
        chk1 ("ferr_no_fp",    rx_bus.o_iqdata_fp, 1'b0);
        chk1 ("ferr_single",   rx_bus.o_frame_err, 1'b0);
        chk12("ferr_hold_i",   rx_bus.o_idata,     12'h006);
        chk12("ferr_hold_q",   rx_bus.o_qdata,     12'h806);
        for (int k = 0; k < 3; k++) sample(12'h111, 12'h222, 1'b0);
        chk1("relock_early", rx_bus.o_lock, 1'b0);
        sample(12'h333, 12'h444, 1'b0);
        chk1 ("relock_lock",  rx_bus.o_lock,      1'b1);
        chk1 ("relock_fp",    rx_bus.o_iqdata_fp, 1'b1);
        chk12("relock_idata", rx_bus.o_idata,     12'h333);
        chk12("relock_qdata", rx_bus.o_qdata,     12'h444);
        chki ("ferr_count",   err_pulses - e0,    1);

        // Idle gaps: 15 cycles harmless, 16 cycles drops lock with one pulse.
        e0 = err_pulses;
        idle(15);
        chk1("tmo15_lock", rx_bus.o_lock,  1'b1);
        chki("tmo15_err",  err_pulses - e0, 0);
        sample(12'h5A5, 12'h0F0, 1'b0);
        chk1 ("tmo15_fp",    rx_bus.o_iqdata_fp, 1'b1);
        chk12("tmo15_idata", rx_bus.o_idata,     12'h5A5);
        idle(16);
        chk1("tmo16_err",  rx_bus.o_frame_err, 1'b1);
        chk1("tmo16_lock", rx_bus.o_lock,      1'b0);
        idle(1);
        chk1("tmo16_single", rx_bus.o_frame_err, 1'b0);
        chki("tmo_count",    err_pulses - e0,    1);

        // Stream picked up mid-sample while hunting.
        n0 = sq_i.size();
        e0 = err_pulses;
        beat(1'b0, 6'h2A);
        beat(1'b0, 6'h15);
        for (int k = 0; k < 3; k++) sample(12'h0AB, 12'h0CD, 1'b0);
        chki("mid_no_strobe", sq_i.size() - n0, 0);
        chk1("mid_lock_low",  rx_bus.o_lock,    1'b0);
        sample(12'h246, 12'h8AC, 1'b0);
        chk1 ("mid_fp",      rx_bus.o_iqdata_fp, 1'b1);
        chk12("mid_idata",   rx_bus.o_idata,     12'h246);
        chk12("mid_qdata",   rx_bus.o_qdata,     12'h8AC);
        chki ("mid_count",   sq_i.size() - n0,   1);
        chki ("mid_no_err",  err_pulses - e0,    0);

        // Async reset between b1 and b2 of I=7FF.
        vi = 12'h7FF;
        vq = 12'h001;
        beat(1'b1, vi[11:6]);
        beat(1'b1, vq[11:6]);
        #1;
        rst_n = 1'b0;
        #1;
        chk12("arst_idata", rx_bus.o_idata,     12'h000);
        chk12("arst_qdata", rx_bus.o_qdata,     12'h000);
        chk1 ("arst_lock",  rx_bus.o_lock,      1'b0);
        chk1 ("arst_fp",    rx_bus.o_iqdata_fp, 1'b0);
        chk1 ("arst_err",   rx_bus.o_frame_err, 1'b0);
        rx_bus.i_rx_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        n0 = sq_i.size();
        beat(1'b0, vi[5:0]);
        beat(1'b0, vq[5:0]);
        chk1("arst_no_fp", rx_bus.o_iqdata_fp, 1'b0);
        for (int k = 0; k < 3; k++) sample(12'h135, 12'h9BD, 1'b0);
        chki("arst_no_strobe", sq_i.size() - n0, 0);
        sample(12'h777, 12'h888, 1'b0);
        chk1 ("arst_relock_fp", rx_bus.o_iqdata_fp, 1'b1);
        chk12("arst_relock_i",  rx_bus.o_idata,     12'h777);
        chk12("arst_relock_q",  rx_bus.o_qdata,     12'h888);
        chki ("arst_count",     sq_i.size() - n0,   1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
